// File: rtl/flag_stack.sv
// Flag register with per-bit write mask, sticky bits and a save/restore stack.
// All state advances on the falling edge of clk; reset is asynchronous.
module flag_stack #(
  parameter int unsigned  N      = 4,
  parameter int unsigned  DEPTH  = 4,
  parameter logic [N-1:0] STICKY = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               in,
  input  logic                       w,
  input  logic [N-1:0]               mask,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  output logic [N-1:0]               flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  stack [0:DEPTH-1];
  logic [N-1:0]  flags_upd;
  logic [N-1:0]  flags_nxt;
  logic [CW-1:0] count_nxt;
  logic          err_nxt;
  logic          do_push;
  logic          do_pop;
  logic          stack_err;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign push_idx = AW'(count);
  assign top_idx  = AW'(count - CW'(1));

  // Push and pop together cancel; neither counts as an error then.
  assign do_push   = push && !pop && !full;
  assign do_pop    = pop && !push && !empty;
  assign stack_err = (push && !pop && full) || (pop && !push && empty);

  // Masked write; sticky bits only accumulate and are zeroed by clr.
  always_comb begin
    flags_upd = flags;
    for (int i = 0; i < int'(N); i++) begin
      if (STICKY[i]) begin
        if (clr)                 flags_upd[i] = 1'b0;
        else if (w && mask[i])   flags_upd[i] = flags[i] | in[i];
      end else if (w && mask[i]) begin
        flags_upd[i] = in[i];
      end
    end
  end

  always_comb begin
    flags_nxt = flags_upd;
    count_nxt = count;
    err_nxt   = err;
    if (do_pop) begin
      flags_nxt = stack[top_idx];
      count_nxt = count - CW'(1);
    end else if (do_push) begin
      count_nxt = count + CW'(1);
    end
    if (stack_err)    err_nxt = 1'b1;
    else if (err_clr) err_nxt = 1'b0;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      flags <= flags_nxt;
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  // Entry storage is not reset; count guards against reading stale entries.
  always_ff @(negedge clk) begin
    if (do_push && !rst) stack[push_idx] <= flags;
  end

endmodule

// File: tb/tb_flag_stack.sv
// Randomized and directed checking of flag_stack (N=4, DEPTH=2, STICKY=4'b0010)
// against a queue-based reference model.
module tb_flag_stack;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 2;
  localparam logic [3:0]  STK   = 4'b0010;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in, mask;
  logic       w, clr, push, pop, err_clr;
  logic [3:0] flags;
  logic [1:0] count;
  logic       full, empty, err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  logic       m_err;

  flag_stack #(.N(N), .DEPTH(DEPTH), .STICKY(STK)) dut (
    .clk(clk), .rst(rst), .in(in), .w(w), .mask(mask), .clr(clr),
    .push(push), .pop(pop), .err_clr(err_clr),
    .flags(flags), .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".flags"}, int'(flags), int'(m_flags));
    check({tag, ".count"}, int'(count), m_stk.size());
    check({tag, ".full"},  int'(full),  int'(m_stk.size() == DEPTH));
    check({tag, ".empty"}, int'(empty), int'(m_stk.size() == 0));
    check({tag, ".err"},   int'(err),   int'(m_err));
  endtask

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic tick(input string tag, input logic [3:0] i_in, input logic [3:0] i_mask,
                      input logic i_w, input logic i_clr, input logic i_push,
                      input logic i_pop, input logic i_eclr);
    logic [3:0] nf;
    logic       bad;
    in = i_in; mask = i_mask; w = i_w; clr = i_clr;
    push = i_push; pop = i_pop; err_clr = i_eclr;
    nf = m_flags;
    for (int i = 0; i < 4; i++) begin
      if (STK[i]) begin
        if (i_clr) nf[i] = 1'b0;
        else if (i_w && i_mask[i]) nf[i] = m_flags[i] | i_in[i];
      end else if (i_w && i_mask[i]) begin
        nf[i] = i_in[i];
      end
    end
    bad = 1'b0;
    if (i_push && !i_pop) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_flags);
      else bad = 1'b1;
    end else if (i_pop && !i_push) begin
      if (m_stk.size() > 0) nf = m_stk.pop_back();
      else bad = 1'b1;
    end
    m_flags = nf;
    if (bad) m_err = 1'b1;
    else if (i_eclr) m_err = 1'b0;
    @(negedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_flags = '0; m_stk.delete(); m_err = 1'b0;
    #1;
    check_all("reset");
    #3;
    rst = 1'b0;
  endtask

  initial begin
    in = '0; mask = '0; w = 0; clr = 0; push = 0; pop = 0; err_clr = 0;
    rst = 1'b0;
    #2;
    do_reset();

    // Basic write and push/pop sequence
    tick("wrA",   4'hA, 4'hF, 1, 0, 0, 0, 0);
    tick("push1", 4'h0, 4'h0, 0, 0, 1, 0, 0);
    tick("pushw", 4'h5, 4'hF, 1, 0, 1, 0, 0);
    tick("pop1",  4'h0, 4'h0, 0, 0, 0, 1, 0);
    tick("pop2",  4'h0, 4'h0, 0, 0, 0, 1, 0);

    // Sticky bit behaviour
    tick("wr2",   4'h2, 4'hF, 1, 0, 0, 0, 0);
    tick("wr0",   4'h0, 4'hF, 1, 0, 0, 0, 0);
    tick("clr",   4'h0, 4'h0, 0, 1, 0, 0, 0);
    tick("clrw",  4'hF, 4'hF, 1, 1, 0, 0, 0);
    tick("mask",  4'h0, 4'h4, 1, 0, 0, 0, 0);

    // Overflow, error clear, underflow, error clear racing a new error
    tick("p1",    4'h0, 4'h0, 0, 0, 1, 0, 0);
    tick("p2",    4'h0, 4'h0, 0, 0, 1, 0, 0);
    tick("ovf",   4'h6, 4'hF, 1, 0, 1, 0, 0);
    tick("eclr",  4'h0, 4'h0, 0, 0, 0, 0, 1);
    tick("q1",    4'h0, 4'h0, 0, 0, 0, 1, 0);
    tick("q2",    4'h0, 4'h0, 0, 0, 0, 1, 0);
    tick("unf",   4'h0, 4'h0, 0, 0, 0, 1, 0);
    tick("eclr2", 4'h0, 4'h0, 0, 0, 0, 0, 1);
    tick("race",  4'h0, 4'h0, 0, 0, 0, 1, 1);
    tick("eclr3", 4'h0, 4'h0, 0, 0, 0, 0, 1);

    // Simultaneous push and pop
    tick("s1",    4'h9, 4'hF, 1, 0, 1, 0, 0);
    tick("pp",    4'h3, 4'hF, 1, 0, 1, 1, 0);
    tick("ppf",   4'h0, 4'h0, 0, 0, 1, 0, 0);
    tick("ppfull",4'hC, 4'hF, 1, 0, 1, 1, 0);

    // Reset raised between edges during a push
    tick("rclr",  4'h0, 4'h0, 0, 0, 0, 1, 1);
    tick("rpush", 4'h7, 4'hF, 1, 0, 1, 0, 0);
    push = 1'b1; w = 1'b1; in = 4'hB;
    #1;
    do_reset();
    tick("rpop",  4'h0, 4'h0, 0, 0, 0, 1, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [3:0] r_in, r_mask;
      logic r_w, r_clr, r_push, r_pop, r_ecl;
      r_in   = 4'($urandom);
      r_mask = 4'($urandom);
      r_w    = ($urandom_range(0, 99) < 60);
      r_clr  = ($urandom_range(0, 99) < 15);
      r_push = ($urandom_range(0, 99) < 35);
      r_pop  = ($urandom_range(0, 99) < 35);
      r_ecl  = ($urandom_range(0, 99) < 20);
      tick("rand", r_in, r_mask, r_w, r_clr, r_push, r_pop, r_ecl);
      if (k == 200) begin
        #2;
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
